// File: rtl/nf_bypass_front_service_pkg.sv
// Shared types for the NFP front-end splitter: metadata layout, routing flags, FSM states.
package nf_bypass_front_service_pkg;

  localparam int unsigned FLAG_BITS = 3;
  localparam int unsigned STAT_BITS = 32;

  localparam logic [FLAG_BITS-1:0] PKT_CHECK   = 3'd1;
  localparam logic [FLAG_BITS-1:0] PKT_FORWARD = 3'd2;

  typedef struct packed {
    logic [31:0]          pkt_id;
    logic [15:0]          pkt_len;
    logic [FLAG_BITS-1:0] pkt_flags;
    logic [12:0]          rsvd;
  } metadata_t;

  localparam int unsigned META_BITS = $bits(metadata_t);

  typedef enum logic [1:0] {
    IDLE,
    META,
    PKT,
    RULE
  } nfbf_state_t;

  // Only packets explicitly flagged for checking go through the NFP service.
  function automatic logic is_nf_path(input metadata_t m);
    return m.pkt_flags == PKT_CHECK;
  endfunction

endpackage

// File: rtl/stream_sel2.sv
// 1-to-2 valid/ready steering mux: side A when i_sel=1, side B otherwise, idle when !i_en.
module stream_sel2 #(
  parameter int unsigned W = 8
) (
  input  logic         i_en,
  input  logic         i_sel,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_a_data,
  output logic         o_a_valid,
  input  logic         i_a_ready,
  output logic [W-1:0] o_b_data,
  output logic         o_b_valid,
  input  logic         i_b_ready
);

  assign o_a_data  = i_data;
  assign o_b_data  = i_data;
  assign o_a_valid = i_en & i_sel & i_valid;
  assign o_b_valid = i_en & ~i_sel & i_valid;
  // Ready follows only the selected side, so the other side cannot stall us.
  assign o_ready   = i_en & (i_sel ? i_a_ready : i_b_ready);

endmodule

// File: rtl/nf_bypass_front_service.sv
// Steers each packet group (meta, packet beats, rule beats) to the NFP path or the bypass path.
// Optional NF_BYPASS_STATS_EN adds the four 32-bit traffic counters; otherwise they read 0.
module nf_bypass_front_service
  import nf_bypass_front_service_pkg::*;
#(
  parameter  int unsigned PKT_BITS        = 512,
  parameter  int unsigned RULE_BITS       = 512,
  localparam int unsigned PKT_EMPTY_BITS  = $clog2(PKT_BITS / 8),
  localparam int unsigned RULE_EMPTY_BITS = $clog2(RULE_BITS / 8)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,

  input  logic [PKT_BITS-1:0]        in_pkt_data,
  input  logic                       in_pkt_valid,
  output logic                       in_pkt_ready,
  input  logic                       in_pkt_sop,
  input  logic                       in_pkt_eop,
  input  logic [PKT_EMPTY_BITS-1:0]  in_pkt_empty,

  input  metadata_t                  in_meta_data,
  input  logic                       in_meta_valid,
  output logic                       in_meta_ready,

  input  logic [RULE_BITS-1:0]       in_usr_data,
  input  logic                       in_usr_valid,
  output logic                       in_usr_ready,
  input  logic                       in_usr_sop,
  input  logic                       in_usr_eop,
  input  logic [RULE_EMPTY_BITS-1:0] in_usr_empty,

  output logic [PKT_BITS-1:0]        out_pkt_data,
  output logic                       out_pkt_valid,
  input  logic                       out_pkt_ready,
  output logic                       out_pkt_sop,
  output logic                       out_pkt_eop,
  output logic [PKT_EMPTY_BITS-1:0]  out_pkt_empty,

  output metadata_t                  out_meta_data,
  output logic                       out_meta_valid,
  input  logic                       out_meta_ready,

  output logic [RULE_BITS-1:0]       out_usr_data,
  output logic                       out_usr_valid,
  input  logic                       out_usr_ready,
  output logic                       out_usr_sop,
  output logic                       out_usr_eop,
  output logic [RULE_EMPTY_BITS-1:0] out_usr_empty,

  output logic [PKT_BITS-1:0]        bypass_pkt_data,
  output logic                       bypass_pkt_valid,
  input  logic                       bypass_pkt_ready,
  output logic                       bypass_pkt_sop,
  output logic                       bypass_pkt_eop,
  output logic [PKT_EMPTY_BITS-1:0]  bypass_pkt_empty,

  output metadata_t                  bypass_meta_data,
  output logic                       bypass_meta_valid,
  input  logic                       bypass_meta_ready,

  output logic [RULE_BITS-1:0]       bypass_usr_data,
  output logic                       bypass_usr_valid,
  input  logic                       bypass_usr_ready,
  output logic                       bypass_usr_sop,
  output logic                       bypass_usr_eop,
  output logic [RULE_EMPTY_BITS-1:0] bypass_usr_empty,

  output logic [STAT_BITS-1:0]       stats_nf_pkt,
  output logic [STAT_BITS-1:0]       stats_bypass_pkt,
  output logic [STAT_BITS-1:0]       stats_bypass_meta,
  output logic [STAT_BITS-1:0]       stats_bypass_rule
);

  localparam int unsigned PKT_PW  = PKT_BITS + 2 + PKT_EMPTY_BITS;
  localparam int unsigned RULE_PW = RULE_BITS + 2 + RULE_EMPTY_BITS;

  nfbf_state_t r_state;
  nfbf_state_t w_state_nxt;
  metadata_t   r_meta;
  logic        r_sel;

  logic w_meta_pop;
  logic w_meta_drive;
  logic w_meta_rdy;
  logic w_meta_hs;
  logic w_pkt_hs;
  logic w_usr_hs;

  logic [PKT_PW-1:0]  w_pkt_pay;
  logic [PKT_PW-1:0]  w_pkt_a_pay;
  logic [PKT_PW-1:0]  w_pkt_b_pay;
  logic [RULE_PW-1:0] w_usr_pay;
  logic [RULE_PW-1:0] w_usr_a_pay;
  logic [RULE_PW-1:0] w_usr_b_pay;

  assign w_meta_drive  = (r_state == META);
  assign w_meta_hs     = w_meta_drive & w_meta_rdy;
  assign w_pkt_hs      = in_pkt_valid & in_pkt_ready;
  assign w_usr_hs      = in_usr_valid & in_usr_ready;
  assign in_meta_ready = w_meta_pop;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; the meta pop is a single-cycle acknowledge out of IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_meta_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_meta_valid) begin
          w_meta_pop  = 1'b1;
          w_state_nxt = META;
        end
      end
      META: if (w_meta_hs)               w_state_nxt = PKT;
      PKT:  if (w_pkt_hs && in_pkt_eop)  w_state_nxt = RULE;
      RULE: if (w_usr_hs && in_usr_eop)  w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  // Routing decision is frozen for the whole packet group at the meta pop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_meta <= '0;
      r_sel  <= 1'b0;
    end else if (w_meta_pop) begin
      r_meta <= in_meta_data;
      r_sel  <= is_nf_path(in_meta_data);
    end
  end

  stream_sel2 #(.W(META_BITS)) u_meta_sel (
    .i_en      (1'b1),
    .i_sel     (r_sel),
    .i_data    (r_meta),
    .i_valid   (w_meta_drive),
    .o_ready   (w_meta_rdy),
    .o_a_data  (out_meta_data),
    .o_a_valid (out_meta_valid),
    .i_a_ready (out_meta_ready),
    .o_b_data  (bypass_meta_data),
    .o_b_valid (bypass_meta_valid),
    .i_b_ready (bypass_meta_ready)
  );

  assign w_pkt_pay = {in_pkt_sop, in_pkt_eop, in_pkt_empty, in_pkt_data};
  assign {out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_data}             = w_pkt_a_pay;
  assign {bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_empty, bypass_pkt_data} = w_pkt_b_pay;

  stream_sel2 #(.W(PKT_PW)) u_pkt_sel (
    .i_en      (r_state == PKT),
    .i_sel     (r_sel),
    .i_data    (w_pkt_pay),
    .i_valid   (in_pkt_valid),
    .o_ready   (in_pkt_ready),
    .o_a_data  (w_pkt_a_pay),
    .o_a_valid (out_pkt_valid),
    .i_a_ready (out_pkt_ready),
    .o_b_data  (w_pkt_b_pay),
    .o_b_valid (bypass_pkt_valid),
    .i_b_ready (bypass_pkt_ready)
  );

  assign w_usr_pay = {in_usr_sop, in_usr_eop, in_usr_empty, in_usr_data};
  assign {out_usr_sop, out_usr_eop, out_usr_empty, out_usr_data}             = w_usr_a_pay;
  assign {bypass_usr_sop, bypass_usr_eop, bypass_usr_empty, bypass_usr_data} = w_usr_b_pay;

  stream_sel2 #(.W(RULE_PW)) u_usr_sel (
    .i_en      (r_state == RULE),
    .i_sel     (r_sel),
    .i_data    (w_usr_pay),
    .i_valid   (in_usr_valid),
    .o_ready   (in_usr_ready),
    .o_a_data  (w_usr_a_pay),
    .o_a_valid (out_usr_valid),
    .i_a_ready (out_usr_ready),
    .o_b_data  (w_usr_b_pay),
    .o_b_valid (bypass_usr_valid),
    .i_b_ready (bypass_usr_ready)
  );

`ifdef NF_BYPASS_STATS_EN
  logic [STAT_BITS-1:0] r_stats_nf_pkt;
  logic [STAT_BITS-1:0] r_stats_bypass_pkt;
  logic [STAT_BITS-1:0] r_stats_bypass_meta;
  logic [STAT_BITS-1:0] r_stats_bypass_rule;

  // Free-running wrap-around counters, bumped on the accepting cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stats_nf_pkt      <= '0;
      r_stats_bypass_pkt  <= '0;
      r_stats_bypass_meta <= '0;
      r_stats_bypass_rule <= '0;
    end else begin
      if (w_pkt_hs && in_pkt_eop) begin
        if (r_sel) r_stats_nf_pkt     <= r_stats_nf_pkt + STAT_BITS'(1);
        else       r_stats_bypass_pkt <= r_stats_bypass_pkt + STAT_BITS'(1);
      end
      if (w_meta_hs && !r_sel)
        r_stats_bypass_meta <= r_stats_bypass_meta + STAT_BITS'(1);
      if (w_usr_hs && in_usr_eop && !r_sel)
        r_stats_bypass_rule <= r_stats_bypass_rule + STAT_BITS'(1);
    end
  end

  assign stats_nf_pkt      = r_stats_nf_pkt;
  assign stats_bypass_pkt  = r_stats_bypass_pkt;
  assign stats_bypass_meta = r_stats_bypass_meta;
  assign stats_bypass_rule = r_stats_bypass_rule;
`else
  assign stats_nf_pkt      = 32'd0;
  assign stats_bypass_pkt  = 32'd0;
  assign stats_bypass_meta = 32'd0;
  assign stats_bypass_rule = 32'd0;
`endif

endmodule

// File: tb/tb_nf_bypass_front_service.sv
// Scoreboard bench for nf_bypass_front_service: drivers queue expected beats per output channel,
// an independent negedge monitor pops and compares every output handshake.
module tb_nf_bypass_front_service;
  import nf_bypass_front_service_pkg::*;

  localparam int unsigned PB  = 512;
  localparam int unsigned EB  = 6;
  localparam int unsigned PW  = PB + 2 + EB;
  localparam int          TMO = 100;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [PB-1:0] in_pkt_data, in_usr_data, out_pkt_data, out_usr_data, bypass_pkt_data, bypass_usr_data;
  logic          in_pkt_valid, in_pkt_ready, in_pkt_sop, in_pkt_eop;
  logic          in_usr_valid, in_usr_ready, in_usr_sop, in_usr_eop;
  logic [EB-1:0] in_pkt_empty, in_usr_empty, out_pkt_empty, out_usr_empty, bypass_pkt_empty, bypass_usr_empty;
  metadata_t     in_meta_data, out_meta_data, bypass_meta_data;
  logic          in_meta_valid, in_meta_ready;
  logic          out_pkt_valid, out_pkt_ready, out_pkt_sop, out_pkt_eop;
  logic          out_meta_valid, out_meta_ready;
  logic          out_usr_valid, out_usr_ready, out_usr_sop, out_usr_eop;
  logic          bypass_pkt_valid, bypass_pkt_ready, bypass_pkt_sop, bypass_pkt_eop;
  logic          bypass_meta_valid, bypass_meta_ready;
  logic          bypass_usr_valid, bypass_usr_ready, bypass_usr_sop, bypass_usr_eop;
  logic [31:0]   stats_nf_pkt, stats_bypass_pkt, stats_bypass_meta, stats_bypass_rule;

  nf_bypass_front_service #(.PKT_BITS(PB), .RULE_BITS(PB)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .in_usr_data(in_usr_data), .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready),
    .in_usr_sop(in_usr_sop), .in_usr_eop(in_usr_eop), .in_usr_empty(in_usr_empty),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_usr_data(out_usr_data), .out_usr_valid(out_usr_valid), .out_usr_ready(out_usr_ready),
    .out_usr_sop(out_usr_sop), .out_usr_eop(out_usr_eop), .out_usr_empty(out_usr_empty),
    .bypass_pkt_data(bypass_pkt_data), .bypass_pkt_valid(bypass_pkt_valid), .bypass_pkt_ready(bypass_pkt_ready),
    .bypass_pkt_sop(bypass_pkt_sop), .bypass_pkt_eop(bypass_pkt_eop), .bypass_pkt_empty(bypass_pkt_empty),
    .bypass_meta_data(bypass_meta_data), .bypass_meta_valid(bypass_meta_valid), .bypass_meta_ready(bypass_meta_ready),
    .bypass_usr_data(bypass_usr_data), .bypass_usr_valid(bypass_usr_valid), .bypass_usr_ready(bypass_usr_ready),
    .bypass_usr_sop(bypass_usr_sop), .bypass_usr_eop(bypass_usr_eop), .bypass_usr_empty(bypass_usr_empty),
    .stats_nf_pkt(stats_nf_pkt), .stats_bypass_pkt(stats_bypass_pkt),
    .stats_bypass_meta(stats_bypass_meta), .stats_bypass_rule(stats_bypass_rule)
  );

  // Channels: 0 out_meta, 1 out_pkt, 2 out_usr, 3 bypass_meta, 4 bypass_pkt, 5 bypass_usr.
  logic [PW-1:0] sbq [6][$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_eop = -1;
  int t_pkt = -1;
  int t_usr = -1;
  bit chk_gap = 1'b0;
  bit chk_tp = 1'b0;
  int unsigned m_nf = 0, m_bp = 0, m_bm = 0, m_br = 0;

  function automatic string chname(input int ch);
    case (ch)
      0: return "out_meta";
      1: return "out_pkt";
      2: return "out_usr";
      3: return "bypass_meta";
      4: return "bypass_pkt";
      default: return "bypass_usr";
    endcase
  endfunction

  function automatic logic [PB-1:0] mkpkt(input logic [15:0] id, input int b);
    logic [31:0] w;
    w = {id, 8'(b), 8'hA5};
    return {16{w}};
  endfunction

  function automatic logic [PB-1:0] mkusr(input logic [15:0] id, input int b);
    logic [31:0] w;
    w = {id, 8'(b), 8'h5C};
    return {16{w}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input int ch, input logic [PW-1:0] act);
    logic [PW-1:0] exp;
    checks++;
    if (sbq[ch].size() == 0) begin
      errors++;
      $display("FAIL %s unexpected beat actual=%h", chname(ch), act);
    end else begin
      exp = sbq[ch].pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", chname(ch), act, exp);
      end
    end
  endtask

  // Monitor: compares every output handshake and the timing relations enabled by the test.
  initial begin
    forever begin
      @(negedge Clk);
      cyc++;
      if (out_meta_valid && out_meta_ready)       sb_pop(0, PW'(out_meta_data));
      if (out_pkt_valid && out_pkt_ready)         sb_pop(1, {out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_data});
      if (out_usr_valid && out_usr_ready)         sb_pop(2, {out_usr_sop, out_usr_eop, out_usr_empty, out_usr_data});
      if (bypass_meta_valid && bypass_meta_ready) sb_pop(3, PW'(bypass_meta_data));
      if (bypass_pkt_valid && bypass_pkt_ready)   sb_pop(4, {bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_empty, bypass_pkt_data});
      if (bypass_usr_valid && bypass_usr_ready)   sb_pop(5, {bypass_usr_sop, bypass_usr_eop, bypass_usr_empty, bypass_usr_data});
      if (out_pkt_valid)    chk("pkt_ready_mirror_nf", 64'(in_pkt_ready), 64'(out_pkt_ready));
      if (bypass_pkt_valid) chk("pkt_ready_mirror_bp", 64'(in_pkt_ready), 64'(bypass_pkt_ready));
      if (out_usr_valid)    chk("usr_ready_mirror_nf", 64'(in_usr_ready), 64'(out_usr_ready));
      if (bypass_usr_valid) chk("usr_ready_mirror_bp", 64'(in_usr_ready), 64'(bypass_usr_ready));
      if (in_pkt_valid && in_pkt_ready) begin
        if (chk_tp && !in_pkt_sop && t_pkt >= 0) chk("pkt_rate", 64'(cyc - t_pkt), 64'd1);
        if (chk_gap && in_pkt_sop && t_eop >= 0) chk("pkt_gap", 64'(cyc - t_eop), 64'd3);
        t_pkt = cyc;
      end
      if (in_usr_valid && in_usr_ready) begin
        if (chk_tp && !in_usr_sop && t_usr >= 0) chk("usr_rate", 64'(cyc - t_usr), 64'd1);
        t_usr = cyc;
        if (in_usr_eop) t_eop = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_hs(input int which);
    int  n;
    logic r;
    n = 0;
    r = 1'b0;
    do begin
      @(negedge Clk);
      n++;
      case (which)
        0:       r = in_meta_ready;
        1:       r = in_pkt_ready;
        default: r = in_usr_ready;
      endcase
    end while (!r && n < TMO);
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL handshake_timeout stream=%0d actual=ready_low expected=ready_within_%0d", which, TMO);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drv_meta(input metadata_t m);
    in_meta_data  = m;
    in_meta_valid = 1'b1;
    wait_hs(0);
    in_meta_valid = 1'b0;
  endtask

  task automatic drv_pkt(input logic [15:0] id, input int np, input logic [EB-1:0] emp);
    for (int b = 0; b < np; b++) begin
      in_pkt_data  = mkpkt(id, b);
      in_pkt_sop   = (b == 0);
      in_pkt_eop   = (b == np - 1);
      in_pkt_empty = (b == np - 1) ? emp : '0;
      in_pkt_valid = 1'b1;
      wait_hs(1);
    end
    in_pkt_valid = 1'b0;
  endtask

  task automatic drv_usr(input logic [15:0] id, input int nr);
    for (int b = 0; b < nr; b++) begin
      in_usr_data  = mkusr(id, b);
      in_usr_sop   = (b == 0);
      in_usr_eop   = (b == nr - 1);
      in_usr_empty = '0;
      in_usr_valid = 1'b1;
      wait_hs(2);
    end
    in_usr_valid = 1'b0;
  endtask

  function automatic metadata_t mkmeta(input bit nf, input logic [15:0] id, input int np);
    metadata_t m;
    m           = '0;
    m.pkt_id    = {16'h0, id};
    m.pkt_len   = 16'(np);
    m.pkt_flags = nf ? PKT_CHECK : PKT_FORWARD;
    return m;
  endfunction

  task automatic send_pkt(input bit nf, input logic [15:0] id, input int np, input int nr,
                          input logic [EB-1:0] emp);
    metadata_t m;
    int base;
    base = nf ? 0 : 3;
    m = mkmeta(nf, id, np);
    sbq[base].push_back(PW'(m));
    for (int b = 0; b < np; b++)
      sbq[base+1].push_back({1'(b == 0), 1'(b == np - 1), (b == np - 1) ? emp : EB'(0), mkpkt(id, b)});
    for (int b = 0; b < nr; b++)
      sbq[base+2].push_back({1'(b == 0), 1'(b == nr - 1), EB'(0), mkusr(id, b)});
    if (nf) m_nf++;
    else begin
      m_bp++;
      m_bm++;
      m_br++;
    end
    fork
      drv_meta(m);
      drv_pkt(id, np, emp);
      drv_usr(id, nr);
    join
  endtask

  task automatic check_stats();
`ifdef NF_BYPASS_STATS_EN
    chk("stats_nf_pkt",      64'(stats_nf_pkt),      64'(m_nf));
    chk("stats_bypass_pkt",  64'(stats_bypass_pkt),  64'(m_bp));
    chk("stats_bypass_meta", 64'(stats_bypass_meta), 64'(m_bm));
    chk("stats_bypass_rule", 64'(stats_bypass_rule), 64'(m_br));
`else
    chk("stats_nf_pkt",      64'(stats_nf_pkt),      64'd0);
    chk("stats_bypass_pkt",  64'(stats_bypass_pkt),  64'd0);
    chk("stats_bypass_meta", 64'(stats_bypass_meta), 64'd0);
    chk("stats_bypass_rule", 64'(stats_bypass_rule), 64'd0);
`endif
  endtask

  task automatic check_idle(input string nm);
    chk(nm, 64'({out_meta_valid, bypass_meta_valid, out_pkt_valid, bypass_pkt_valid,
                 out_usr_valid, bypass_usr_valid, in_meta_ready, in_pkt_ready, in_usr_ready}), 64'd0);
  endtask

  initial begin
    bit pat [8];
    metadata_t m;
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    in_pkt_data = '0; in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0; in_pkt_empty = '0;
    in_usr_data = '0; in_usr_valid = 1'b0; in_usr_sop = 1'b0; in_usr_eop = 1'b0; in_usr_empty = '0;
    in_meta_data = '0; in_meta_valid = 1'b0;
    out_pkt_ready = 1'b1; out_meta_ready = 1'b1; out_usr_ready = 1'b1;
    bypass_pkt_ready = 1'b1; bypass_meta_ready = 1'b1; bypass_usr_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle("reset_idle");
    check_stats();
    step(1);
    Rst_n = 1'b1;
    step(1);

    // Bypass packet: 3 packet beats, 1 rule beat.
    send_pkt(1'b0, 16'h0001, 3, 1, '0);
    step(2);
    check_stats();

    // NFP packet with a partial last beat.
    send_pkt(1'b1, 16'h0002, 2, 2, 6'd10);
    step(2);
    check_stats();

    // Bypass side held off must not slow the NFP packet.
    bypass_pkt_ready = 1'b0;
    chk_tp = 1'b1;
    send_pkt(1'b1, 16'h0003, 4, 2, 6'd3);
    chk_tp = 1'b0;
    bypass_pkt_ready = 1'b1;
    step(2);

    // NFP downstream stalls mid-packet.
    fork
      send_pkt(1'b1, 16'h0004, 4, 1, 6'd0);
      begin
        for (int i = 0; i < 8; i++) begin
          out_pkt_ready = pat[i];
          step(1);
        end
        out_pkt_ready = 1'b1;
      end
    join
    step(2);
    check_stats();

    // Back-to-back alternating packets at full rate.
    t_eop = -1;
    chk_gap = 1'b1;
    chk_tp = 1'b1;
    send_pkt(1'b1, 16'h0005, 2, 1, 6'd0);
    send_pkt(1'b0, 16'h0006, 3, 2, 6'd7);
    send_pkt(1'b1, 16'h0007, 1, 1, 6'd1);
    send_pkt(1'b0, 16'h0008, 2, 1, 6'd0);
    chk_gap = 1'b0;
    chk_tp = 1'b0;
    step(2);
    check_stats();

    // Reset after the first of four NFP packet beats.
    m = mkmeta(1'b1, 16'h0009, 4);
    sbq[0].push_back(PW'(m));
    sbq[1].push_back({1'b1, 1'b0, EB'(0), mkpkt(16'h0009, 0)});
    fork
      drv_meta(m);
      begin
        in_pkt_data  = mkpkt(16'h0009, 0);
        in_pkt_sop   = 1'b1;
        in_pkt_eop   = 1'b0;
        in_pkt_empty = '0;
        in_pkt_valid = 1'b1;
        wait_hs(1);
      end
    join
    in_pkt_data = mkpkt(16'h0009, 1);
    in_pkt_sop  = 1'b0;
    #1;
    Rst_n = 1'b0;
    m_nf = 0; m_bp = 0; m_bm = 0; m_br = 0;
    @(negedge Clk);
    check_idle("mid_pkt_reset_idle");
    check_stats();
    in_pkt_valid = 1'b0;
    step(1);
    Rst_n = 1'b1;
    step(1);
    send_pkt(1'b0, 16'h000A, 2, 1, 6'd0);
    step(2);
    check_stats();

    for (int ch = 0; ch < 6; ch++)
      chk({"sb_left_", chname(ch)}, 64'(sbq[ch].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
